// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART frame parser slice: FSM state encoding,
//   error code constants, the default start-of-frame byte and a helper that
//   sizes buffer address fields.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_CSUM = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_OVR  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Address width for a buffer of 'depth' entries; never below one bit.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// uart_frame_parser_if
//   Payload stream from the frame parser to the command logic.
//   Signals:
//     payload_valid_o  source has a payload byte
//     payload_ready_i  sink accepts the byte
//     payload_data_o   payload byte
//     payload_last_o   final byte of the frame
//   Handshake: a byte transfers on every rising clock edge where
//   payload_valid_o and payload_ready_i are both high. Once valid is raised,
//   data/last stay unchanged until that transfer; valid never depends on ready.
//   Modports: master = parser (source), slave = consumer (sink).
interface uart_frame_parser_if;

    logic       payload_valid_o;
    logic       payload_ready_i;
    logic [7:0] payload_data_o;
    logic       payload_last_o;

    modport master (
        output payload_valid_o,
        output payload_data_o,
        output payload_last_o,
        input  payload_ready_i
    );

    modport slave (
        input  payload_valid_o,
        input  payload_data_o,
        input  payload_last_o,
        output payload_ready_i
    );

endinterface

// File: rtl/uart_frame_buf.sv
// uart_frame_buf
//   Payload storage: DEPTH x 8 register array, one synchronous write port and
//   one combinational read port. Storage has no reset; contents are only
//   meaningful for the frame most recently written.
//   Ports:
//     clk_i     clock
//     we_i      write enable
//     waddr_i   write address
//     wdata_i   write data
//     raddr_i   read address
//     rdata_o   read data (combinational)
module uart_frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = uart_pkg::addr_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Hunts for SOF_BYTE in the UART byte stream, collects a length-prefixed
//   payload, checks an 8-bit additive checksum (length + payload bytes) and
//   replays verified payloads on the payload stream. Malformed frames are
//   dropped with a one-cycle err_o pulse and a held err_code_o.
//   Optional feature: define UART_FRAME_TIMEOUT_EN to abort a frame after
//   TIMEOUT_CYCLES idle cycles in LEN/PAYLOAD/CSUM (error code 3).
//   Ports:
//     clk_i           clock
//     resetn_i        asynchronous active-low reset
//     datain_valid_i  one-cycle byte strobe from the receiver
//     datain_i        received byte
//     pl              payload stream (master side)
//     frame_len_o     length of the frame being drained, held until next drain
//     err_o           one-cycle error pulse
//     err_code_o      error code, held until next error
//     state_o         current FSM state (debug)
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    input  logic                       datain_valid_i,
    input  logic [7:0]                 datain_i,
    uart_frame_parser_if.master        pl,
    output logic [7:0]                 frame_len_o,
    output logic                       err_o,
    output logic [1:0]                 err_code_o,
    output state_t                     state_o
);

    localparam int unsigned AW = addr_width(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] rd_q, rd_d;
    logic       valid_d, last_d, err_d;
    logic [7:0] data_d, flen_d;
    logic [1:0] code_d;

    logic          buf_we;
    logic [AW-1:0] buf_raddr;
    logic [7:0]    buf_rdata;
    logic [7:0]    rd_inc;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    assign rd_inc = rd_q + 8'd1;

    // The output data register is loaded one step ahead: entry 0 when the
    // checksum passes, otherwise the entry after the one being handed over.
    always_comb begin
        buf_raddr = '0;
        if (state_q != CSUM) begin
            buf_raddr = rd_inc[AW-1:0];
        end
    end

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk_i   (clk_i),
        .we_i    (buf_we),
        .waddr_i (idx_q[AW-1:0]),
        .wdata_i (datain_i),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        rd_d    = rd_q;
        valid_d = pl.payload_valid_o;
        data_d  = pl.payload_data_o;
        last_d  = pl.payload_last_o;
        flen_d  = frame_len_o;
        err_d   = 1'b0;
        code_d  = err_code_o;
        buf_we  = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (datain_valid_i && datain_i == SOF_BYTE) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (datain_valid_i) begin
                    // A rejected length byte returns to HUNT without being
                    // treated as a possible SOF.
                    if (datain_i == 8'd0 || datain_i > 8'(MAX_LEN)) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = HUNT;
                    end else begin
                        len_d   = datain_i;
                        sum_d   = datain_i;
                        idx_d   = 8'd0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (datain_valid_i) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + datain_i;
                    idx_d  = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (datain_valid_i) begin
                    if (datain_i == sum_q) begin
                        state_d = DRAIN;
                        flen_d  = len_q;
                        rd_d    = 8'd0;
                        valid_d = 1'b1;
                        data_d  = buf_rdata;
                        last_d  = (len_q == 8'd1);
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CSUM;
                        state_d = HUNT;
                    end
                end
            end
            DRAIN: begin
                // Receiver bytes cannot be buffered while draining.
                if (datain_valid_i) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVR;
                end
                if (pl.payload_valid_o && pl.payload_ready_i) begin
                    if (pl.payload_last_o) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = HUNT;
                    end else begin
                        rd_d   = rd_inc;
                        data_d = buf_rdata;
                        last_d = (rd_inc == len_q - 8'd1);
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

`ifdef UART_FRAME_TIMEOUT_EN
        tmo_d = '0;
        if (state_q == LEN || state_q == PAYLOAD || state_q == CSUM) begin
            if (!datain_valid_i) begin
                if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TMO;
                    state_d = HUNT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q            <= HUNT;
            len_q              <= 8'd0;
            sum_q              <= 8'd0;
            idx_q              <= 8'd0;
            rd_q               <= 8'd0;
            pl.payload_valid_o <= 1'b0;
            pl.payload_data_o  <= 8'd0;
            pl.payload_last_o  <= 1'b0;
            frame_len_o        <= 8'd0;
            err_o              <= 1'b0;
            err_code_o         <= 2'd0;
        end else begin
            state_q            <= state_d;
            len_q              <= len_d;
            sum_q              <= sum_d;
            idx_q              <= idx_d;
            rd_q               <= rd_d;
            pl.payload_valid_o <= valid_d;
            pl.payload_data_o  <= data_d;
            pl.payload_last_o  <= last_d;
            frame_len_o        <= flen_d;
            err_o              <= err_d;
            err_code_o         <= code_d;
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign state_o = state_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;
  import uart_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] din = 8'd0;
  logic [7:0] frame_len;
  logic       err;
  logic [1:0] err_code;
  state_t     state;

  int checks = 0;
  int errors = 0;

  uart_frame_parser_if pl_if();

  uart_frame_parser #(
    .SOF_BYTE       (8'hA5),
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk_i          (clk),
    .resetn_i       (resetn),
    .datain_valid_i (dv),
    .datain_i       (din),
    .pl             (pl_if.master),
    .frame_len_o    (frame_len),
    .err_o          (err),
    .err_code_o     (err_code),
    .state_o        (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor / scoreboard queues ----------------
  logic [8:0] got_q[$];   // {last, data} of each accepted payload byte
  logic [8:0] exp_q[$];
  logic [1:0] err_q[$];

  always @(negedge clk) begin
    if (pl_if.payload_valid_o && pl_if.payload_ready_i)
      got_q.push_back({pl_if.payload_last_o, pl_if.payload_data_o});
    if (err)
      err_q.push_back(err_code);
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    dv = 1'b1;
    din = b;
    @(posedge clk); #1;
    dv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    pl_if.payload_ready_i = 1'b0;
    #12;
    checks++; if (pl_if.payload_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pl_if.payload_valid_o); end
    checks++; if (pl_if.payload_data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", pl_if.payload_data_o); end
    checks++; if (pl_if.payload_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", pl_if.payload_last_o); end
    checks++; if (frame_len !== 8'h00) begin errors++; $display("FAIL reset_flen: got %h want 00", frame_len); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", err_code); end
    checks++; if (state !== HUNT) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, HUNT); end
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(1);
  endtask

  task automatic test_good_frame();
    logic [7:0] frame [6];
    frame = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    got_q.delete(); err_q.delete();
    pl_if.payload_ready_i = 1'b1;
    foreach (frame[i]) send_byte(frame[i]);
    // first valid right after the checksum strobe
    checks++; if (pl_if.payload_valid_o !== 1'b1) begin errors++; $display("FAIL good_valid0: got %b want 1", pl_if.payload_valid_o); end
    checks++; if (pl_if.payload_data_o !== 8'h11) begin errors++; $display("FAIL good_data0: got %h want 11", pl_if.payload_data_o); end
    checks++; if (frame_len !== 8'd3) begin errors++; $display("FAIL good_flen: got %0d want 3", frame_len); end
    idle(1);
    checks++; if (pl_if.payload_data_o !== 8'h22 || pl_if.payload_valid_o !== 1'b1) begin errors++; $display("FAIL good_data1: got %h/%b want 22/1", pl_if.payload_data_o, pl_if.payload_valid_o); end
    idle(1);
    checks++; if (pl_if.payload_data_o !== 8'h33 || pl_if.payload_last_o !== 1'b1) begin errors++; $display("FAIL good_data2: got %h last %b want 33 last 1", pl_if.payload_data_o, pl_if.payload_last_o); end
    idle(1);
    checks++; if (pl_if.payload_valid_o !== 1'b0) begin errors++; $display("FAIL good_valid_drop: got %b want 0", pl_if.payload_valid_o); end
    checks++; if (state !== HUNT) begin errors++; $display("FAIL good_state: got %0d want %0d", state, HUNT); end
    checks++; if (err_q.size() !== 0) begin errors++; $display("FAIL good_noerr: got %0d errors want 0", err_q.size()); end
    exp_q = '{9'h011, 9'h022, 9'h133};
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL good_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL good_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] bad [5];
    logic [7:0] good [4];
    bad  = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
    good = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    got_q.delete(); err_q.delete();
    pl_if.payload_ready_i = 1'b1;
    foreach (bad[i]) send_byte(bad[i]);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL csum_err: got %b want 1", err); end
    checks++; if (err_code !== ERR_CSUM) begin errors++; $display("FAIL csum_code: got %0d want 0", err_code); end
    checks++; if (state !== HUNT) begin errors++; $display("FAIL csum_state: got %0d want %0d", state, HUNT); end
    idle(1);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL csum_pulse: got %b want 0", err); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL csum_nopayload: got %0d bytes want 0", got_q.size()); end
    foreach (good[i]) send_byte(good[i]);
    checks++; if (pl_if.payload_valid_o !== 1'b1 || pl_if.payload_data_o !== 8'h7E || pl_if.payload_last_o !== 1'b1)
      begin errors++; $display("FAIL csum_next: got v%b %h l%b want v1 7e l1", pl_if.payload_valid_o, pl_if.payload_data_o, pl_if.payload_last_o); end
    checks++; if (frame_len !== 8'd1) begin errors++; $display("FAIL csum_next_flen: got %0d want 1", frame_len); end
    idle(1);
    checks++; if (pl_if.payload_valid_o !== 1'b0) begin errors++; $display("FAIL csum_next_drop: got %b want 0", pl_if.payload_valid_o); end
    checks++; if (err_q.size() !== 1) begin errors++; $display("FAIL csum_errcount: got %0d want 1", err_q.size()); end
  endtask

  task automatic test_length_errors();
    got_q.delete(); err_q.delete();
    send_byte(8'h5A);
    send_byte(8'hFF);
    idle(1);
    checks++; if (err_q.size() !== 0 || state !== HUNT) begin errors++; $display("FAIL len_garbage: got %0d errors state %0d want 0 / HUNT", err_q.size(), state); end
    send_byte(8'hA5);
    send_byte(8'h00);
    checks++; if (err !== 1'b1 || err_code !== ERR_LEN) begin errors++; $display("FAIL len_zero: got err %b code %0d want 1 / 1", err, err_code); end
    send_byte(8'hA5);
    send_byte(8'h11);
    checks++; if (err !== 1'b1 || err_code !== ERR_LEN) begin errors++; $display("FAIL len_over: got err %b code %0d want 1 / 1", err, err_code); end
    // a rejected length of A5 is not taken as a new SOF
    send_byte(8'hA5);
    send_byte(8'hA5);
    checks++; if (err !== 1'b1 || err_code !== ERR_LEN) begin errors++; $display("FAIL len_sof: got err %b code %0d want 1 / 1", err, err_code); end
    checks++; if (state !== HUNT) begin errors++; $display("FAIL len_sof_state: got %0d want %0d", state, HUNT); end
    idle(1);
    checks++; if (err_q.size() !== 3) begin errors++; $display("FAIL len_errcount: got %0d want 3", err_q.size()); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL len_nopayload: got %0d want 0", got_q.size()); end
  endtask

  task automatic test_drain_stall();
    logic [7:0] frame [7];
    logic       pat [4];
    logic       pv, pr;
    logic [7:0] pd;
    frame = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0E};
    pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
    got_q.delete(); err_q.delete();
    pl_if.payload_ready_i = 1'b0;
    foreach (frame[i]) send_byte(frame[i]);
    checks++; if (pl_if.payload_valid_o !== 1'b1 || pl_if.payload_data_o !== 8'h01) begin errors++; $display("FAIL stall_first: got v%b %h want v1 01", pl_if.payload_valid_o, pl_if.payload_data_o); end
    for (int c = 0; c < 10; c++) begin
      pl_if.payload_ready_i = pat[c % 4];
      if (c == 2) begin dv = 1'b1; din = 8'h77; end
      if (c == 7) begin dv = 1'b1; din = 8'h88; end  // same cycle as last handshake
      pv = pl_if.payload_valid_o; pd = pl_if.payload_data_o; pr = pl_if.payload_ready_i;
      @(posedge clk); #1;
      dv = 1'b0;
      if (pv && !pr) begin
        checks++; if (pl_if.payload_data_o !== pd || pl_if.payload_valid_o !== 1'b1) begin errors++; $display("FAIL stall_hold c%0d: got v%b %h want v1 %h", c, pl_if.payload_valid_o, pl_if.payload_data_o, pd); end
      end
      if (c == 2 || c == 7) begin
        checks++; if (err !== 1'b1 || err_code !== ERR_OVR) begin errors++; $display("FAIL stall_ovr c%0d: got err %b code %0d want 1 / 2", c, err, err_code); end
      end
    end
    pl_if.payload_ready_i = 1'b1;
    checks++; if (pl_if.payload_valid_o !== 1'b0 || state !== HUNT) begin errors++; $display("FAIL stall_end: got v%b state %0d want v0 HUNT", pl_if.payload_valid_o, state); end
    exp_q = '{9'h001, 9'h002, 9'h003, 9'h104};
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (err_q.size() !== 2) begin errors++; $display("FAIL stall_errcount: got %0d want 2", err_q.size()); end
  endtask

  task automatic test_timeout();
    got_q.delete(); err_q.delete();
    pl_if.payload_ready_i = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
`ifdef UART_FRAME_TIMEOUT_EN
    begin
      int n;
      n = 0;
      for (int k = 1; k <= 60; k++) begin
        @(posedge clk); #1;
        if (err) begin n = k; break; end
      end
      checks++; if (n !== 50) begin errors++; $display("FAIL tmo_cycles: got %0d want 50", n); end
      checks++; if (err_code !== ERR_TMO) begin errors++; $display("FAIL tmo_code: got %0d want 3", err_code); end
      checks++; if (state !== HUNT) begin errors++; $display("FAIL tmo_state: got %0d want %0d", state, HUNT); end
      idle(2);
      checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL tmo_nopayload: got %0d want 0", got_q.size()); end
    end
`else
    idle(60);
    checks++; if (err_q.size() !== 0) begin errors++; $display("FAIL notmo_err: got %0d errors want 0", err_q.size()); end
    checks++; if (state !== PAYLOAD) begin errors++; $display("FAIL notmo_state: got %0d want %0d", state, PAYLOAD); end
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h0E);
    checks++; if (pl_if.payload_valid_o !== 1'b1 || pl_if.payload_data_o !== 8'h01) begin errors++; $display("FAIL notmo_first: got v%b %h want v1 01", pl_if.payload_valid_o, pl_if.payload_data_o); end
    idle(5);
    exp_q = '{9'h001, 9'h002, 9'h003, 9'h104};
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL notmo_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    else foreach (exp_q[i]) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL notmo_byte%0d: got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_len !== 8'd4) begin errors++; $display("FAIL notmo_flen: got %0d want 4", frame_len); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] frame [5];
    frame = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h01};
    pl_if.payload_ready_i = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h01);
    send_byte(8'h02);
    resetn = 1'b0;
    #1;
    checks++; if (state !== HUNT) begin errors++; $display("FAIL rst_mid_state: got %0d want %0d", state, HUNT); end
    checks++; if (pl_if.payload_valid_o !== 1'b0 || pl_if.payload_data_o !== 8'h00 || pl_if.payload_last_o !== 1'b0)
      begin errors++; $display("FAIL rst_mid_stream: got v%b %h l%b want v0 00 l0", pl_if.payload_valid_o, pl_if.payload_data_o, pl_if.payload_last_o); end
    checks++; if (frame_len !== 8'h00 || err !== 1'b0 || err_code !== 2'd0)
      begin errors++; $display("FAIL rst_mid_misc: got flen %h err %b code %0d want 00 0 0", frame_len, err, err_code); end
    #2;
    resetn = 1'b1;
    @(posedge clk); #1;
    got_q.delete(); err_q.delete();
    foreach (frame[i]) send_byte(frame[i]);
    checks++; if (pl_if.payload_valid_o !== 1'b1 || pl_if.payload_data_o !== 8'hAA || pl_if.payload_last_o !== 1'b0)
      begin errors++; $display("FAIL rst_next0: got v%b %h l%b want v1 aa l0", pl_if.payload_valid_o, pl_if.payload_data_o, pl_if.payload_last_o); end
    idle(1);
    checks++; if (pl_if.payload_data_o !== 8'h55 || pl_if.payload_last_o !== 1'b1)
      begin errors++; $display("FAIL rst_next1: got %h l%b want 55 l1", pl_if.payload_data_o, pl_if.payload_last_o); end
    checks++; if (frame_len !== 8'd2) begin errors++; $display("FAIL rst_next_flen: got %0d want 2", frame_len); end
    idle(1);
    checks++; if (got_q.size() !== 2 || err_q.size() !== 0) begin errors++; $display("FAIL rst_next_counts: got %0d bytes %0d errors want 2 / 0", got_q.size(), err_q.size()); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    pl_if.payload_ready_i = 1'b0;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_length_errors();
    test_drain_stall();
    test_timeout();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
